add_round_key_stage: RTL and testbench



---
 rtl/add_round_key_stage_pkg.sv | 53 +++++
 rtl/add_round_key_stage_key_step.sv | 28 ++
 rtl/add_round_key_stage.sv | 70 +++++++
 tb/tb_add_round_key_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_round_key_stage_pkg.sv
// Shared AES-128 constants for the AddRoundKey stage and its on-the-fly key schedule.
package add_round_key_stage_pkg;

  localparam int BYTE   = 8;
  localparam int DWORD  = 32;
  localparam int LENGTH = 128;
  localparam int NR     = 10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ark_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constant for rounds 1..10; anything else maps to zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/add_round_key_stage_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
module aes_key_step
  import add_round_key_stage_pkg::*;
(
  input  logic [LENGTH-1:0] key,
  input  logic [BYTE-1:0]   rc,
  output logic [LENGTH-1:0] next_key
);

  logic [DWORD-1:0] w0, w1, w2, w3;
  logic [DWORD-1:0] rot, sub, t;
  logic [DWORD-1:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;

  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  assign t   = sub ^ {rc, 24'h000000};

  // Each new word chains off the one just produced.
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage with an on-the-fly AES-128 round key schedule.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module add_round_key_stage
  import add_round_key_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [LENGTH-1:0] key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_data,
  output logic [3:0]        out_round
);

  localparam logic [3:0] NR4 = 4'(NR);

  ark_state_t        state;
  logic [LENGTH-1:0] ck;
  logic [LENGTH-1:0] rk;
  logic [3:0]        rnd;

  logic [LENGTH-1:0] ks_src;
  logic [BYTE-1:0]   ks_rc;
  logic [LENGTH-1:0] ks_next;
  logic              in_fire;

  // A key load and the last round both restart the schedule from round 1.
  assign ks_src = key_load ? key_in : ((rnd == NR4) ? ck : rk);
  assign ks_rc  = (key_load || rnd == NR4) ? rcon(4'd1) : rcon(rnd + 4'd1);

  aes_key_step u_key_step (
    .key      (ks_src),
    .rc       (ks_rc),
    .next_key (ks_next)
  );

  assign in_ready = (state == RUN) && !key_load && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ck        <= '0;
      rk        <= '0;
      rnd       <= 4'd1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= 4'd0;
    end else if (key_load) begin
      state     <= RUN;
      ck        <= key_in;
      rk        <= ks_next;
      rnd       <= 4'd1;
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_data  <= in_data ^ rk;
      out_round <= rnd;
      out_valid <= 1'b1;
      rk        <= ks_next;
      rnd       <= (rnd == NR4) ? 4'd1 : rnd + 4'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Bench for add_round_key_stage: FIPS-197 vectors, handshake corners and a randomized scoreboard run.
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [3:0]   out_round;

  int total = 0;
  int bad = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] mrk [11];
  logic [131:0] exp_q [$];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    logic [3:0]   rnd;
  } vec_t;
  vec_t vec [11];

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  add_round_key_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_round (out_round)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Classic word-array key expansion; mrk[r] is the round-r key.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [127:0] d1, d2, d3;
    int           m_rnd;
    bit           m_loaded;
    bit           kl;
    bit           exp_ready;

    build_sbox();

    // Reset values.
    #2;
    chk("rst_out_valid", 132'(out_valid), 132'(0));
    chk("rst_in_ready", 132'(in_ready), 132'(0));
    chk("rst_out_round", 132'(out_round), 132'(0));
    chk("rst_out_data", 132'(out_data), 132'(0));
    #10 rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    #1 chk("idle_in_ready", 132'(in_ready), 132'(0));
    tick();
    chk("idle_no_accept", 132'(out_valid), 132'(0));

    // Load the FIPS-197 key.
    in_valid = 1'b0; key_load = 1'b1; key_in = KEY_A; out_ready = 1'b1;
    tick();
    key_load = 1'b0;
    expand(KEY_A);

    // Eleven back-to-back blocks: rounds 1..10 then wrap to round 1.
    for (int i = 0; i < 11; i++) begin
      vec[i].rnd  = 4'((i % 10) + 1);
      vec[i].din  = (i == 0 || i == 1 || i == 9 || i == 10) ? 128'h0 : rand128();
      vec[i].dout = vec[i].din ^ mrk[(i % 10) + 1];
    end
    vec[0].dout  = 128'ha0fafe1788542cb123a339392a6c7605;
    vec[1].dout  = 128'hf2c295f27a96b9435935807a7359f67f;
    vec[9].dout  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vec[10].dout = 128'ha0fafe1788542cb123a339392a6c7605;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_data = vec[i].din;
      #1 chk($sformatf("vec%0d_in_ready", i), 132'(in_ready), 132'(1));
      tick();
      chk($sformatf("vec%0d_valid", i), 132'(out_valid), 132'(1));
      chk($sformatf("vec%0d_round", i), 132'(out_round), 132'(vec[i].rnd));
      chk($sformatf("vec%0d_data", i), 132'(out_data), 132'(vec[i].dout));
    end

    // Backpressure: result held stable for three stalled cycles.
    d1 = rand128(); d2 = rand128();
    in_data = d1;
    tick();
    out_ready = 1'b0; in_data = d2;
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_in_ready", 132'(in_ready), 132'(0));
      tick();
      chk("stall_valid", 132'(out_valid), 132'(1));
      chk("stall_data", {out_round, out_data}, {4'd2, d1 ^ mrk[2]});
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", 132'(in_ready), 132'(1));
    tick();
    chk("release_data", {out_round, out_data}, {4'd3, d2 ^ mrk[3]});
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 132'(out_valid), 132'(0));

    // key_load collides with in_valid while a result is pending.
    in_valid = 1'b1; in_data = rand128(); out_ready = 1'b0;
    tick();
    chk("pend_valid", 132'(out_valid), 132'(1));
    d3 = rand128();
    key_load = 1'b1; key_in = rand128(); in_data = d3;
    #1 chk("kl_in_ready", 132'(in_ready), 132'(0));
    tick();
    key_load = 1'b0;
    expand(key_in);
    chk("kl_discard", 132'(out_valid), 132'(0));
    out_ready = 1'b1;
    tick();
    chk("kl_restart", {out_valid, out_round, out_data}, {1'b1, 4'd1, d3 ^ mrk[1]});

    // Advance to round 5, then reset asynchronously.
    for (int r = 2; r <= 5; r++) begin
      in_data = rand128();
      tick();
    end
    chk("pre_rst_round", 132'(out_round), 132'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 132'(out_valid), 132'(0));
    chk("arst_in_ready", 132'(in_ready), 132'(0));
    chk("arst_out_round", 132'(out_round), 132'(0));
    chk("arst_out_data", 132'(out_data), 132'(0));
    #2 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("post_rst_in_ready", 132'(in_ready), 132'(0));
      chk("post_rst_valid", 132'(out_valid), 132'(0));
    end

    // Randomized run against the scoreboard.
    m_loaded = 1'b0; m_rnd = 1;
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      kl = ($urandom_range(0, 24) == 0) || (!m_loaded && $urandom_range(0, 2) == 0);
      key_load  = kl;
      key_in    = rand128();
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rand128();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = m_loaded && !kl && (exp_q.size() == 0 || out_ready);
      chk("rnd_in_ready", 132'(in_ready), 132'(exp_ready));
      chk("rnd_out_valid", 132'(out_valid), 132'(exp_q.size() != 0));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        chk("rnd_out", {out_round, out_data}, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (kl) begin
        expand(key_in);
        m_rnd = 1; m_loaded = 1'b1;
        exp_q.delete();
      end else if (in_valid && exp_ready) begin
        exp_q.push_back({4'(m_rnd), in_data ^ mrk[m_rnd]});
        m_rnd = (m_rnd == 10) ? 1 : m_rnd + 1;
      end
      tick();
    end
    key_load = 1'b0; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
